// File: rtl/uart_sdram_pkg.sv
// uart_sdram_pkg: shared scheduler state encoding, grant constants and bus defaults
// for the UART to SDRAM loopback path.
package uart_sdram_pkg;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} sched_state_t;
    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;
    localparam int BURST_LEN_DEF = 4;
    localparam int ADDR_W_DEF = 20;
endpackage

// File: rtl/uart_sdram_sched_if.sv
// uart_sdram_sched_if: FIFO fill levels in, burst request/complete handshake and status out.
interface uart_sdram_sched_if import uart_sdram_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W = 5
);
    logic [CNT_W-1:0] wfifo_cnt;
    logic [CNT_W-1:0] rfifo_cnt;
    logic wr_trig;
    logic [ADDR_W-1:0] wr_addr;
    logic wr_done;
    logic rd_trig;
    logic [ADDR_W-1:0] rd_addr;
    logic rd_done;
    logic [ADDR_W:0] stored;
    logic busy;
    logic err;
    modport master (
        input wfifo_cnt, rfifo_cnt, wr_done, rd_done,
        output wr_trig, wr_addr, rd_trig, rd_addr, stored, busy, err
    );
    modport slave (
        output wfifo_cnt, rfifo_cnt, wr_done, rd_done,
        input wr_trig, wr_addr, rd_trig, rd_addr, stored, busy, err
    );
endinterface

// File: rtl/uart_sdram_sched_tmo_cnt.sv
// sched_tmo_cnt: loadable up-counter that stops at TERM and flags it.
module sched_tmo_cnt #(
    parameter int TERM = 1023
) (
    input logic clk,
    input logic rst_n,
    input logic load,
    input logic en,
    output logic hit
);
    localparam int W = $clog2(TERM + 1);
    logic [W-1:0] cnt;
    assign hit = cnt == W'(TERM);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= '0;
        else if (en && !hit) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_sdram_sched.sv
// uart_sdram_sched: round-robin write/read burst scheduler over a circular SDRAM buffer,
// one request in flight, each guarded by a completion timeout.
module uart_sdram_sched import uart_sdram_pkg::*; #(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W = 5,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURSTS = 1024,
    parameter int TMO_CYC = 1023
) (
    input logic clk,
    input logic rst_n,
    uart_sdram_sched_if.master bus
);
    localparam int PTR_W = MAX_BURSTS > 1 ? $clog2(MAX_BURSTS) : 1;
    localparam logic [ADDR_W:0] MAX_B = (ADDR_W + 1)'(MAX_BURSTS);
    localparam logic [CNT_W-1:0] BL_C = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(FIFO_DEPTH - BURST_LEN);
    sched_state_t state;
    logic last_grant;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0] stored;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic wr_trig, rd_trig, busy, err;
    logic wr_ok, rd_ok, grant_wr, tmo_hit;
    assign wr_ok = bus.wfifo_cnt >= BL_C && stored < MAX_B;
    // read needs room for a whole burst in the TX FIFO
    assign rd_ok = stored != '0 && bus.rfifo_cnt <= RD_LIM;
    assign grant_wr = wr_ok && (!rd_ok || last_grant == GRANT_RD);
    sched_tmo_cnt #(.TERM(TMO_CYC)) u_tmo (
        .clk(clk),
        .rst_n(rst_n),
        .load(state == WR_REQ || state == RD_REQ),
        .en(state == WR_WAIT || state == RD_WAIT),
        .hit(tmo_hit)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            last_grant <= GRANT_RD;
            wr_ptr <= '0;
            rd_ptr <= '0;
            stored <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            wr_trig <= 1'b0;
            rd_trig <= 1'b0;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            wr_trig <= 1'b0;
            rd_trig <= 1'b0;
            case (state)
                IDLE: if (wr_ok || rd_ok) begin
                    state <= grant_wr ? WR_REQ : RD_REQ;
                    last_grant <= grant_wr ? GRANT_WR : GRANT_RD;
                    wr_trig <= grant_wr;
                    rd_trig <= !grant_wr;
                    wr_addr <= grant_wr ? ADDR_W'(wr_ptr) * ADDR_W'(BURST_LEN) : wr_addr;
                    rd_addr <= grant_wr ? rd_addr : ADDR_W'(rd_ptr) * ADDR_W'(BURST_LEN);
                    busy <= 1'b1;
                end
                WR_REQ: state <= WR_WAIT;
                RD_REQ: state <= RD_WAIT;
                WR_WAIT: if (bus.wr_done || tmo_hit) begin
                    wr_ptr <= bus.wr_done ? wr_ptr + 1'b1 : wr_ptr;
                    stored <= bus.wr_done ? stored + 1'b1 : stored;
                    err <= err | !bus.wr_done;
                    state <= IDLE;
                    busy <= 1'b0;
                end
                RD_WAIT: if (bus.rd_done || tmo_hit) begin
                    rd_ptr <= bus.rd_done ? rd_ptr + 1'b1 : rd_ptr;
                    stored <= bus.rd_done ? stored - 1'b1 : stored;
                    err <= err | !bus.rd_done;
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    assign bus.wr_trig = wr_trig;
    assign bus.rd_trig = rd_trig;
    assign bus.wr_addr = wr_addr;
    assign bus.rd_addr = rd_addr;
    assign bus.stored = stored;
    assign bus.busy = busy;
    assign bus.err = err;
endmodule

// File: tb/tb_uart_sdram_sched.sv
// tb_uart_sdram_sched: table-driven eligibility/arbitration rows plus hand sequences for
// alternation, timeout retry and async reset, with a trig scoreboard.
module tb_uart_sdram_sched;
    localparam int MB = 4;
    localparam int TMO = 1023;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    typedef struct {logic wr; logic [19:0] addr;} exp_t;
    typedef struct {logic [4:0] w; logic [4:0] r; int kind; logic [19:0] addr; int dly; int st;} row_t;
    exp_t q[$];
    row_t rows[15];
    uart_sdram_sched_if #(.ADDR_W(20), .CNT_W(5)) bus();
    uart_sdram_sched #(.MAX_BURSTS(MB), .TMO_CYC(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(output logic seen);
        int t = 0;
        while (!(bus.wr_trig || bus.rd_trig) && t < 20) begin
            tick();
            t++;
        end
        seen = bus.wr_trig || bus.rd_trig;
        chk("trig_within_bound", int'(seen), 1);
    endtask

    task automatic serve(input int n);
        logic seen, is_wr;
        for (int k = 0; k < n; k++) begin
            wait_trig(seen);
            if (!seen) return;
            is_wr = bus.wr_trig;
            tick();
            bus.wr_done = is_wr;
            bus.rd_done = !is_wr;
            tick();
            bus.wr_done = 1'b0;
            bus.rd_done = 1'b0;
        end
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_wr_trig"}, int'(bus.wr_trig), 0);
        chk({tag, "_rd_trig"}, int'(bus.rd_trig), 0);
        chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        chk({tag, "_stored"}, int'(bus.stored), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
    endtask

    always @(negedge clk) if (rst_n && (bus.wr_trig || bus.rd_trig)) begin
        exp_t e;
        chk("single_trig", int'(bus.wr_trig & bus.rd_trig), 0);
        chk("stored_le_max", int'(bus.stored <= 21'(MB)), 1);
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_trig: wr=%0b rd=%0b with no request expected at %0t", bus.wr_trig, bus.rd_trig, $time);
        end else begin
            e = q.pop_front();
            chk("trig_is_wr", int'(bus.wr_trig), int'(e.wr));
            chk("trig_addr", int'(e.wr ? bus.wr_addr : bus.rd_addr), int'(e.addr));
        end
    end

    initial begin
        logic seen;
        int t;
        // kind: 0 none, 1 write, 2 read; addr and stored derived by hand for MAX_BURSTS=4
        rows[0] = '{5'd4, 5'd0, 1, 20'd0, 5, 1};
        rows[1] = '{5'd0, 5'd0, 2, 20'd0, 1, 0};
        rows[2] = '{5'd3, 5'd0, 0, 20'd0, 0, 0};
        rows[3] = '{5'd16, 5'd0, 1, 20'd4, 2, 1};
        rows[4] = '{5'd16, 5'd0, 2, 20'd4, 1, 0};
        rows[5] = '{5'd4, 5'd13, 1, 20'd8, 3, 1};
        rows[6] = '{5'd0, 5'd13, 0, 20'd0, 0, 1};
        rows[7] = '{5'd0, 5'd12, 2, 20'd8, 1, 0};
        rows[8] = '{5'd4, 5'd16, 1, 20'd12, 1, 1};
        rows[9] = '{5'd4, 5'd16, 1, 20'd0, 2, 2};
        rows[10] = '{5'd4, 5'd16, 1, 20'd4, 1, 3};
        rows[11] = '{5'd4, 5'd16, 1, 20'd8, 1, 4};
        rows[12] = '{5'd4, 5'd16, 0, 20'd0, 0, 4};
        rows[13] = '{5'd4, 5'd0, 2, 20'd12, 1, 3};
        rows[14] = '{5'd4, 5'd16, 1, 20'd12, 1, 4};
        bus.wfifo_cnt = '0;
        bus.rfifo_cnt = 5'd16;
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        tick();
        outputs_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        outputs_zero("post_reset");
        for (int i = 0; i < 15; i++) begin
            bus.wfifo_cnt = rows[i].w;
            bus.rfifo_cnt = rows[i].r;
            if (rows[i].kind != 0) q.push_back('{rows[i].kind == 1, rows[i].addr});
            tick();
            chk($sformatf("row%0d_trig", i), int'({bus.wr_trig, bus.rd_trig}),
                rows[i].kind == 1 ? 2 : rows[i].kind == 2 ? 1 : 0);
            bus.wfifo_cnt = '0;
            bus.rfifo_cnt = 5'd16;
            if (rows[i].kind != 0) begin
                repeat (rows[i].dly) tick();
                bus.wr_done = rows[i].kind == 1;
                bus.rd_done = rows[i].kind == 2;
                tick();
                bus.wr_done = 1'b0;
                bus.rd_done = 1'b0;
            end else repeat (3) tick();
            chk($sformatf("row%0d_stored", i), int'(bus.stored), rows[i].st);
            chk($sformatf("row%0d_busy", i), int'(bus.busy), 0);
        end
        // alternation: two writes with reads blocked, then both eligible
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.wfifo_cnt = 5'd8;
        q.push_back('{1'b1, 20'd0});
        q.push_back('{1'b1, 20'd4});
        serve(2);
        bus.rfifo_cnt = 5'd0;
        q.push_back('{1'b0, 20'd0});
        q.push_back('{1'b1, 20'd8});
        q.push_back('{1'b0, 20'd4});
        q.push_back('{1'b1, 20'd12});
        serve(4);
        bus.rfifo_cnt = 5'd16;
        tick();
        chk("alt_stored", int'(bus.stored), 2);
        chk("alt_queue_drained", q.size(), 0);
        // timeout with retry at the same address
        q.push_back('{1'b1, 20'd0});
        q.push_back('{1'b1, 20'd0});
        wait_trig(seen);
        repeat (TMO - 1) tick();
        chk("tmo_err_early", int'(bus.err), 0);
        t = 0;
        while (!bus.err && t < 20) begin
            tick();
            t++;
        end
        chk("tmo_err_set", int'(bus.err), 1);
        chk("tmo_busy", int'(bus.busy), 0);
        chk("tmo_stored", int'(bus.stored), 2);
        serve(1);
        bus.wfifo_cnt = '0;
        tick();
        chk("retry_stored", int'(bus.stored), 3);
        chk("err_sticky", int'(bus.err), 1);
        // reset during RD_WAIT, then stray done pulses
        bus.rfifo_cnt = 5'd0;
        q.push_back('{1'b0, 20'd8});
        wait_trig(seen);
        tick();
        chk("rdwait_busy", int'(bus.busy), 1);
        #3 rst_n = 1'b0;
        #1 outputs_zero("async_reset");
        bus.rfifo_cnt = 5'd16;
        tick();
        rst_n = 1'b1;
        tick();
        bus.rd_done = 1'b1;
        bus.wr_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        bus.wr_done = 1'b0;
        repeat (2) tick();
        chk("stray_stored", int'(bus.stored), 0);
        chk("stray_busy", int'(bus.busy), 0);
        chk("final_queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_sdram_sched.md
Name: uart_sdram_sched

Overview:
- Scheduler between the UART byte path and the SDRAM controller (Sdram_Top) in the UART→SDRAM loopback design.
- Watches write-FIFO fill (UART RX side) and read-FIFO fill (UART TX side).
- Issues one burst request at a time to Sdram_Top via wr_trig/rd_trig, with write/read addresses drawn from a circular buffer held in SDRAM.
- Arbitrates write vs read round-robin and guards every request with a completion timeout.

Parameters:
- BURST_LEN, 4: words per SDRAM burst; also the FIFO threshold in entries.
- ADDR_W, 20: SDRAM word-address width (bank+row+column flattened).
- CNT_W, 5: width of FIFO usedw counts.
- FIFO_DEPTH, 16: depth of the read FIFO.
- MAX_BURSTS, 1024: capacity of the circular buffer in bursts. Power of two, ≤ 2^ADDR_W / BURST_LEN.
- TMO_CYC, 1023: cycles allowed from trig to done before error.

Ports:
- clk, in, 1: system clock, 50 MHz.
- rst_n, in, 1: asynchronous active-low reset.
- wfifo_cnt, in, CNT_W: entries held in the write FIFO.
- rfifo_cnt, in, CNT_W: entries held in the read FIFO.
- wr_trig, out, 1: one-cycle pulse requesting a BURST_LEN write at wr_addr.
- wr_addr, out, ADDR_W: write burst start address; stable from trig to done.
- wr_done, in, 1: one-cycle pulse from Sdram_Top when the write burst completes.
- rd_trig, out, 1: one-cycle pulse requesting a BURST_LEN read at rd_addr.
- rd_addr, out, ADDR_W: read burst start address; stable from trig to done.
- rd_done, in, 1: one-cycle pulse when the read burst completes.
- stored, out, ADDR_W+1: bursts written but not yet read.
- busy, out, 1: high in any state other than IDLE.
- err, out, 1: sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values: every output 0; wr_ptr=rd_ptr=0; stored=0; last_grant=READ (so write wins the first tie); state=IDLE.
- Eligibility, evaluated combinationally in IDLE:
  - wr_ok = (wfifo_cnt ≥ BURST_LEN) && (stored < MAX_BURSTS)
  - rd_ok = (stored > 0) && (FIFO_DEPTH − rfifo_cnt ≥ BURST_LEN)
- States:
  - IDLE:
    - Both ok: grant the type opposite to last_grant.
    - One ok: grant that type.
    - Neither ok: stay in IDLE.
    - On grant: go to WR_REQ or RD_REQ and update last_grant.
  - WR_REQ: wr_trig=1 for exactly one cycle; wr_addr = wr_ptr×BURST_LEN; load timeout counter to 0; go to WR_WAIT.
  - WR_WAIT:
    - wr_done → wr_ptr += 1 (mod MAX_BURSTS), stored += 1, go to IDLE.
    - Counter reaches TMO_CYC → err=1, go to IDLE with no pointer update.
  - RD_REQ / RD_WAIT: same as the write pair, using rd_ptr, rd_trig and rd_done; on rd_done, stored −= 1.
- Latency: eligibility sampled in IDLE → trig asserted the next cycle. Minimum request-to-request spacing is 3 cycles (IDLE, REQ, WAIT with done).
- Done pulses handled:
  - A done pulse not matching the current WAIT state (stray, or arriving in IDLE/REQ) is ignored.
  - wr_done and rd_done in the same cycle: only the one matching the state is acted on.
- Wrap-around: pointers wrap from MAX_BURSTS−1 to 0. Address arithmetic is unsigned, truncated to ADDR_W.
- stored never exceeds MAX_BURSTS and never underflows; this follows from the eligibility rules and is a verification assertion.
- Full buffer (stored = MAX_BURSTS): writes are blocked until a read completes. The UART RX FIFO may overflow upstream; that is not this block's concern.
- err does not block further operation.
- A timed-out burst is retried because the pointers are unchanged.
- Reset mid-burst: all state returns to reset values immediately. Sdram_Top is reset by the same rst_n.
- FIFO counts are assumed to be sampled on clk (FIFOs are on clk); no synchronisers.

Decomposition:
- Package uart_sdram_pkg:
  - State encoding localparams (IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT).
  - GRANT_WR / GRANT_RD constants.
  - Defaults for BURST_LEN and ADDR_W, shared with Sdram_Top and the top level.
- One sub-module: sched_tmo_cnt, a loadable up-counter with terminal flag, reused for both wait states.
- Arbitration and pointer logic stay inline.

Test Plan:
1. wfifo_cnt=4, rfifo_cnt=0, stored=0 → wr_trig pulse at wr_addr=0. Assert wr_done 5 cycles later → stored=1, back in IDLE. Next cycle rd_ok only → rd_trig at rd_addr=0.
2. Both eligible continuously (wfifo_cnt=8, stored=2, rfifo_cnt=0) → grants alternate W,R,W,R starting with W after reset.
3. MAX_BURSTS=4 build: issue 4 writes without reads → 5th write withheld (wr_trig stays 0, stored=4). Then one read; after rd_done the next write goes to wr_addr=0 (wrap).
4. rfifo_cnt=13, stored=1 → no rd_trig (free space 3 < 4). Drop rfifo_cnt to 12 → rd_trig next cycle.
5. wr_trig issued, no wr_done for TMO_CYC cycles → err=1, state IDLE, wr_ptr unchanged. Next wr_trig repeats the same wr_addr.
6. Assert rst_n=0 during RD_WAIT → all outputs 0 immediately. Stray rd_done after reset release → ignored, stored stays 0.
